// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
package rf_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  // Starvation counter width; saturates at its all-ones value.
  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] StarveMax = {CntW{1'b1}};

  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared at commit. Register 0 never holds a pending write.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rs1_idx,
  input  logic [AW-1:0] rs2_idx,
  input  logic [AW-1:0] rd_idx,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          rd_busy
);

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;

  // Next state: clear first so a same-cycle set for a new producer wins.
  always_comb begin
    sb_d = sb_q;
    if (clr_en) begin
      sb_d[clr_idx] = 1'b0;
    end
    if (set_en) begin
      sb_d[set_idx] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // Scoreboard state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Raw lookups; forwarding adjustments are made by the caller.
  always_comb begin
    rs1_busy = sb_q[rs1_idx];
    rs2_busy = sb_q[rs2_idx];
    rd_busy  = sb_q[rd_idx];
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single reg-file write port between the ALU (A) and the
// LSU/MDU (B), registers the write, and generates issue hazards/forwarding.
module rf_wb_scheduler
  import rf_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rs1,
  input  logic [AW-1:0] iss_rs2,
  input  logic [AW-1:0] iss_rd,
  input  logic          iss_wr,
  output logic          iss_ready,
  output logic          rs1_fwd,
  output logic          rs2_fwd,
  input  logic          a_valid,
  input  logic [AW-1:0] a_rd,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_rd,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          wb_we,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_data
);

  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_q;
  logic [CntW-1:0] starve_d;
  logic            grant_a;
  logic            grant_b;
  logic            accept;
  reg_idx_t        acc_rd;
  word_t           acc_data;
  logic            sb_rs1;
  logic            sb_rs2;
  logic            sb_rd;
  logic            hit1;
  logic            hit2;
  logic            busy1;
  logic            busy2;
  logic            waw;
  logic            iss_ok;
  logic            iss_fire;

  // Arbitration: A has priority unless B has lost too many cycles in a row.
  always_comb begin
    grant_a  = a_valid & (~b_valid | (starve_q < Limit));
    grant_b  = b_valid & ~grant_a;
    accept   = grant_a | grant_b;
    acc_rd   = grant_a ? a_rd : b_rd;
    acc_data = grant_a ? a_data : b_data;
    starve_d = '0;
    if (b_valid && !grant_b) begin
      starve_d = (starve_q == StarveMax) ? StarveMax : starve_q + 1'b1;
    end
  end

  // Starvation counter and registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      starve_q <= starve_d;
      wb_we    <= accept & (acc_rd != '0);
      if (accept) begin
        wb_rd   <= acc_rd;
        wb_data <= acc_data;
      end
    end
  end

  // Hazards: a committing write to a source resolves it by forwarding, but a
  // pending write to rd is never overtaken, even in its commit cycle.
  always_comb begin
    hit1     = wb_we & (wb_rd == iss_rs1) & (iss_rs1 != '0);
    hit2     = wb_we & (wb_rd == iss_rs2) & (iss_rs2 != '0);
    busy1    = sb_rs1 & ~hit1;
    busy2    = sb_rs2 & ~hit2;
    waw      = iss_wr & sb_rd & (iss_rd != '0);
    iss_ok   = ~(busy1 | busy2 | waw);
    iss_fire = iss_valid & iss_ok & rst & iss_wr & (iss_rd != '0);
  end

  // Handshake outputs are held low while reset is asserted.
  always_comb begin
    a_ready   = rst & grant_a;
    b_ready   = rst & grant_b;
    iss_ready = rst & iss_ok;
    rs1_fwd   = rst & hit1;
    rs2_fwd   = rst & hit2;
  end

  rf_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_fire),
    .set_idx  (iss_rd),
    .clr_en   (wb_we),
    .clr_idx  (wb_rd),
    .rs1_idx  (iss_rs1),
    .rs2_idx  (iss_rs2),
    .rd_idx   (iss_rd),
    .rs1_busy (sb_rs1),
    .rs2_busy (sb_rs2),
    .rd_busy  (sb_rd)
  );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler with hand-computed expectations.
module tb_rf_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic [4:0]  iss_rd;
  logic        iss_wr;
  logic        iss_ready;
  logic        rs1_fwd;
  logic        rs2_fwd;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;

  rf_wb_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_wr    (iss_wr),
    .iss_ready (iss_ready),
    .rs1_fwd   (rs1_fwd),
    .rs2_fwd   (rs2_fwd),
    .a_valid   (a_valid),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_wr = 0;
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wr);
    iss_valid = 1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_wr = wr;
  endtask

  // Both sources valid every cycle (A->r1/0xA0, B->r2/0xB0). With limit 4, B
  // wins on every fifth cycle. Caller is positioned mid-cycle at cycle 0.
  task automatic arb_run(input string tag, input int n, input bit chk_wb0);
    bit prev_b = 0;
    bit exp_b;
    a_valid = 1; a_rd = 5'd1; a_data = 32'hA0;
    b_valid = 1; b_rd = 5'd2; b_data = 32'hB0;
    for (int c = 0; c < n; c++) begin
      #1;
      exp_b = ((c % 5) == 4);
      chk($sformatf("%s_a_ready_c%0d", tag, c), {31'b0, a_ready}, {31'b0, ~exp_b});
      chk($sformatf("%s_b_ready_c%0d", tag, c), {31'b0, b_ready}, {31'b0, exp_b});
      if (c > 0 || chk_wb0) begin
        chk($sformatf("%s_wb_data_c%0d", tag, c), wb_data, prev_b ? 32'hB0 : 32'hA0);
      end
      if (c == 5) chk($sformatf("%s_starve_c5", tag), {28'b0, dut.starve_q}, 32'd0);
      prev_b = exp_b;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 0;
    // Reset state with a request pending.
    a_valid = 1; a_rd = 5'd3; a_data = 32'h11;
    #2;
    chk("rst_a_ready", {31'b0, a_ready}, 0);
    chk("rst_wb_we", {31'b0, wb_we}, 0);
    chk("rst_wb_rd", {27'b0, wb_rd}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_iss_ready", {31'b0, iss_ready}, 0);
    chk("rst_sb", dut.u_sb.sb_q, 0);

    // 1: first accept after release, latency 1.
    @(negedge clk);
    rst = 1;
    #1;
    chk("t1_a_ready", {31'b0, a_ready}, 1);
    tick();
    a_valid = 0;
    #1;
    chk("t1_wb_we", {31'b0, wb_we}, 1);
    chk("t1_wb_rd", {27'b0, wb_rd}, 3);
    chk("t1_wb_data", wb_data, 32'h11);
    tick();
    #1;
    chk("t1_wb_we_drop", {31'b0, wb_we}, 0);
    chk("t1_wb_rd_hold", {27'b0, wb_rd}, 3);

    // 2: starvation-limited arbitration.
    arb_run("t2", 10, 1'b0);
    tick();

    // 3: RAW hazard resolved by forwarding in the commit cycle.
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    #1;
    chk("t3_iss_rd5_ready", {31'b0, iss_ready}, 1);
    tick();
    issue(5'd5, 5'd0, 5'd6, 1'b1);
    #1;
    chk("t3_raw_stall", {31'b0, iss_ready}, 0);
    chk("t3_no_fwd", {31'b0, rs1_fwd}, 0);
    tick();
    b_valid = 1; b_rd = 5'd5; b_data = 32'h55;
    #1;
    chk("t3_b_ready", {31'b0, b_ready}, 1);
    chk("t3_stall_hold", {31'b0, iss_ready}, 0);
    tick();
    b_valid = 0;
    #1;
    chk("t3_wb_rd5", {27'b0, wb_rd}, 5);
    chk("t3_rs1_fwd", {31'b0, rs1_fwd}, 1);
    chk("t3_rs2_fwd", {31'b0, rs2_fwd}, 0);
    chk("t3_ready_fwd", {31'b0, iss_ready}, 1);
    tick();
    issue(5'd0, 5'd5, 5'd0, 1'b0);
    #1;
    chk("t3_r5_clear", {31'b0, iss_ready}, 1);
    chk("t3_sb_r6", dut.u_sb.sb_q, 32'h40);
    tick();

    // 4: WAW stays stalled through the commit cycle.
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    #1;
    chk("t4_first_rd7", {31'b0, iss_ready}, 1);
    tick();
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    a_valid = 1; a_rd = 5'd7; a_data = 32'h77;
    #1;
    chk("t4_waw_stall", {31'b0, iss_ready}, 0);
    chk("t4_a_ready", {31'b0, a_ready}, 1);
    tick();
    a_valid = 0;
    #1;
    chk("t4_commit_wb_rd", {27'b0, wb_rd}, 7);
    chk("t4_commit_stall", {31'b0, iss_ready}, 0);
    tick();
    #1;
    chk("t4_ready_after", {31'b0, iss_ready}, 1);
    iss_valid = 0;
    tick();

    // 5: register zero.
    a_valid = 1; a_rd = 5'd0; a_data = 32'hFFFF;
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    chk("t5_a_ready", {31'b0, a_ready}, 1);
    chk("t5_iss_ready", {31'b0, iss_ready}, 1);
    tick();
    a_valid = 0;
    issue(5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("t5_wb_we", {31'b0, wb_we}, 0);
    chk("t5_rs1_fwd", {31'b0, rs1_fwd}, 0);
    chk("t5_sb", dut.u_sb.sb_q, 32'h40);
    tick();

    // 6: asynchronous reset mid-operation.
    issue(5'd0, 5'd0, 5'd2, 1'b1);
    tick();
    issue(5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    iss_valid = 0;
    a_valid = 1; a_rd = 5'd1; a_data = 32'hA1;
    b_valid = 1; b_rd = 5'd3; b_data = 32'hB3;
    tick();
    tick();
    tick();
    #1;
    chk("t6_pre_starve", {28'b0, dut.starve_q}, 3);
    chk("t6_pre_sb", dut.u_sb.sb_q, 32'h244);
    chk("t6_pre_wb_we", {31'b0, wb_we}, 1);
    #1;
    rst = 0;
    #1;
    chk("t6_sb", dut.u_sb.sb_q, 0);
    chk("t6_starve", {28'b0, dut.starve_q}, 0);
    chk("t6_wb_we", {31'b0, wb_we}, 0);
    chk("t6_wb_rd", {27'b0, wb_rd}, 0);
    chk("t6_wb_data", wb_data, 0);
    chk("t6_a_ready", {31'b0, a_ready}, 0);
    chk("t6_b_ready", {31'b0, b_ready}, 0);
    tick();
    @(negedge clk);
    rst = 1;
    arb_run("t6_fresh", 6, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
